// File: rtl/mult_div_unit.sv
// Execute-stage multiply/divide unit: owns HI/LO, runs mult/multu/div/divu with a
// fixed latency and serves mfhi/mflo reads and mthi/mtlo writes.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDUop,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        HILOsel,
    output logic        Busy,
    output logic [31:0] MDout,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t      r_state;
    logic [CW-1:0] r_cnt;
    logic        r_busy;
    logic [31:0] r_hi, r_lo;
    logic [31:0] r_temp_hi, r_temp_lo;
    logic        r_temp_we;

    logic [63:0] w_prod_s, w_prod_u;
    logic [31:0] w_a_mag, w_b_mag, w_q_mag, w_r_mag;
    logic [31:0] w_res_hi, w_res_lo;
    logic        w_res_we, w_op_valid, w_b_zero;

    // Signed product: low 64 bits of the sign-extended operands are exact.
    assign w_prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign w_prod_u = {32'b0, A} * {32'b0, B};

    // Signed divide done on magnitudes, so INT_MIN / -1 wraps to INT_MIN cleanly.
    assign w_b_zero = (B == 32'd0);
    assign w_a_mag  = A[31] ? (32'd0 - A) : A;
    assign w_b_mag  = B[31] ? (32'd0 - B) : B;
    assign w_q_mag  = w_b_zero ? 32'd0 : (w_a_mag / w_b_mag);
    assign w_r_mag  = w_b_zero ? 32'd0 : (w_a_mag % w_b_mag);

    assign w_op_valid = (MDUop >= OP_MULT) && (MDUop <= OP_DIVU);

    always_comb begin
        w_res_hi = 32'd0;
        w_res_lo = 32'd0;
        w_res_we = 1'b1;
        case (MDUop)
            OP_MULT: begin
                w_res_hi = w_prod_s[63:32];
                w_res_lo = w_prod_s[31:0];
            end
            OP_MULTU: begin
                w_res_hi = w_prod_u[63:32];
                w_res_lo = w_prod_u[31:0];
            end
            OP_DIV: begin
                w_res_lo = (A[31] ^ B[31]) ? (32'd0 - w_q_mag) : w_q_mag;
                w_res_hi = A[31] ? (32'd0 - w_r_mag) : w_r_mag;
                w_res_we = !w_b_zero;
            end
            OP_DIVU: begin
                w_res_lo = w_b_zero ? 32'd0 : (A / B);
                w_res_hi = w_b_zero ? 32'd0 : (A % B);
                w_res_we = !w_b_zero;
            end
            default: w_res_we = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_temp_hi <= 32'd0;
            r_temp_lo <= 32'd0;
            r_temp_we <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Start && w_op_valid) begin
                        r_temp_hi <= w_res_hi;
                        r_temp_lo <= w_res_lo;
                        r_temp_we <= w_res_we;
                        r_cnt     <= (MDUop <= OP_MULTU) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                        r_busy    <= 1'b1;
                        r_state   <= S_BUSY;
                    end else if (!Start && MDUop == OP_MTHI) begin
                        r_hi <= A;
                    end else if (!Start && MDUop == OP_MTLO) begin
                        r_lo <= A;
                    end
                end
                S_BUSY: begin
                    if (r_cnt == CW'(1)) begin
                        if (r_temp_we) begin
                            r_hi <= r_temp_hi;
                            r_lo <= r_temp_lo;
                        end
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign Busy  = r_busy;
    assign HI    = r_hi;
    assign LO    = r_lo;
    assign MDout = HILOsel ? r_hi : r_lo;
endmodule
